// File: rtl/frame_receiver.sv
`default_nettype none
//==============================================================================
// Module   : frame_receiver
// Brief    : Frame-ready triggered packetiser: header, size-limited data
//            pass-through, trailer with error flag, sequence and checksum.
// Revision : 1.0 - initial release
//==============================================================================
module frame_receiver #(
    parameter logic [15:0] HDR_MAGIC = 16'hA55A,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_ready,
    input  logic [15:0] i_frame_size,
    input  logic [31:0] i_in_data,
    input  logic        i_in_vld,
    output logic        o_in_rdy,
    output logic [31:0] o_pkt_data,
    output logic        o_pkt_vld,
    input  logic        i_pkt_rdy,
    output logic        o_pkt_sop,
    output logic        o_pkt_eop,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_TRAILER = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_ready_prev;
    logic [15:0] r_size;
    logic [15:0] r_remaining;
    logic [15:0] r_checksum;
    logic [15:0] r_tcnt;
    logic        r_err;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    logic        w_start;
    logic        w_overrun;
    logic        w_in_xfer;
    logic        w_pkt_xfer;
    logic        w_last_word;
    logic        w_timeout;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [7:0]  w_err_cnt_next;

    assign w_start     = i_frame_ready & ~r_ready_prev;
    assign w_overrun   = w_start & (r_state != S_IDLE);
    assign w_in_xfer   = (r_state == S_DATA) & i_in_vld & o_in_rdy;
    assign w_pkt_xfer  = o_pkt_vld & i_pkt_rdy;
    assign w_last_word = w_in_xfer & (r_remaining == 16'd1);
    assign w_timeout   = (r_state == S_DATA) & ~i_in_vld & (r_tcnt == (TIMEOUT - 16'd1));

    // A timeout and an overrun may land in the same cycle; both are counted.
    assign w_err_inc      = {1'b0, w_timeout} + {1'b0, w_overrun};
    assign w_err_sum      = {1'b0, r_err_cnt} + {7'd0, w_err_inc};
    assign w_err_cnt_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_pkt_xfer) begin
                    w_next_state = (r_size == 16'd0) ? S_TRAILER : S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_word || w_timeout) begin
                    w_next_state = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (w_pkt_xfer) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_rdy   = 1'b0;
        o_pkt_data = 32'd0;
        o_pkt_vld  = 1'b0;
        o_pkt_sop  = 1'b0;
        o_pkt_eop  = 1'b0;
        case (r_state)
            S_HEADER: begin
                o_pkt_vld  = 1'b1;
                o_pkt_sop  = 1'b1;
                o_pkt_data = {HDR_MAGIC, r_size};
            end
            S_DATA: begin
                o_pkt_vld  = i_in_vld;
                o_pkt_data = i_in_data;
                o_in_rdy   = i_pkt_rdy;
            end
            S_TRAILER: begin
                o_pkt_vld  = 1'b1;
                o_pkt_eop  = 1'b1;
                o_pkt_data = {r_err, r_frame_cnt[14:0], r_checksum};
            end
            default: begin
                o_pkt_vld = 1'b0;
            end
        endcase
    end

    // ready_prev resets high so a level already asserted at reset release is not a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_prev <= 1'b1;
            r_size       <= 16'd0;
            r_remaining  <= 16'd0;
            r_checksum   <= 16'd0;
            r_tcnt       <= 16'd0;
            r_err        <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_ready_prev <= i_frame_ready;
            r_err_cnt    <= w_err_cnt_next;

            if ((r_state == S_IDLE) && w_start) begin
                r_size      <= i_frame_size;
                r_remaining <= i_frame_size;
                r_checksum  <= 16'd0;
                r_tcnt      <= 16'd0;
                r_err       <= 1'b0;
            end

            if (w_in_xfer) begin
                r_remaining <= r_remaining - 16'd1;
                r_checksum  <= r_checksum + i_in_data[31:16] + i_in_data[15:0];
                r_tcnt      <= 16'd0;
            end else if ((r_state == S_DATA) && !i_in_vld) begin
                r_tcnt <= r_tcnt + 16'd1;
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == S_DATA) begin
                // Source is offering a word; only the host is stalling.
                r_tcnt <= 16'd0;
            end

            if ((r_state == S_TRAILER) && w_pkt_xfer) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_cnt = r_frame_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_frame_receiver
// Brief    : Scoreboard bench for frame_receiver with a frame-level model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_frame_receiver;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fr;
    logic [15:0] fsize;
    logic [31:0] in_data;
    logic        in_vld;
    logic        o_in_rdy;
    logic [31:0] o_pkt_data;
    logic        o_pkt_vld;
    logic        pkt_rdy;
    logic        o_pkt_sop;
    logic        o_pkt_eop;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    frame_receiver #(
        .HDR_MAGIC (16'hA55A),
        .TIMEOUT   (16'(TO))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_ready (fr),
        .i_frame_size  (fsize),
        .i_in_data     (in_data),
        .i_in_vld      (in_vld),
        .o_in_rdy      (o_in_rdy),
        .o_pkt_data    (o_pkt_data),
        .o_pkt_vld     (o_pkt_vld),
        .i_pkt_rdy     (pkt_rdy),
        .o_pkt_sop     (o_pkt_sop),
        .o_pkt_eop     (o_pkt_eop),
        .o_busy        (o_busy),
        .o_frame_cnt   (o_frame_cnt),
        .o_err_cnt     (o_err_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } pkt_t;

    pkt_t        exp_q[$];
    pkt_t        mon_e;
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          mfc        = 0;
    int          merr       = 0;
    int          inrdy_seen = 0;
    int          rdy_mode   = 1;   // 0 random, 1 always ready, 2 toggle
    logic [31:0] wbuf[0:15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Host ready generator
    initial begin
        pkt_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pkt_rdy = 1'($urandom_range(0, 1));
                1:       pkt_rdy = 1'b1;
                default: pkt_rdy = ~pkt_rdy;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted packet word
    always @(negedge clk) begin
        if (!rst) begin
            if (o_in_rdy) begin
                inrdy_seen++;
                check("in_rdy_vs_host", 64'(pkt_rdy), 64'(1));
            end
            if (!o_busy) begin
                check("idle_outputs", 64'({o_pkt_vld, o_in_rdy, o_pkt_sop, o_pkt_eop}), 64'(0));
            end
            if (o_pkt_vld && pkt_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got %h sop=%b eop=%b required no word",
                             o_pkt_data, o_pkt_sop, o_pkt_eop);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pkt_word", 64'({o_pkt_data, o_pkt_sop, o_pkt_eop}), 64'(mon_e));
                end
            end
        end
    end

    task automatic pulse(input int size);
        fr    = 1'b1;
        fsize = 16'(size);
        @(posedge clk);
        #1;
        fr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int b    = 0;
        bit done = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        in_data = d;
        in_vld  = 1'b1;
        while (!done && b < 200) begin
            @(negedge clk);
            done = o_in_rdy;
            b++;
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        if (!done) begin
            check("src_xfer_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (o_busy && b < 300);
        check("idle_reached", 64'(o_busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: header, the first m words, trailer; m < size means a stall.
    task automatic run_frame(input int size, input int m, input bit gaps, input int ovr_at);
        int unsigned csum = 0;
        bit          err  = (m < size);
        exp_q.push_back(pkt_t'{data: {16'hA55A, 16'(size)}, sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(pkt_t'{data: wbuf[i], sop: 1'b0, eop: 1'b0});
            csum = (csum + (wbuf[i] >> 16) + (wbuf[i] & 32'hFFFF)) % 65536;
        end
        exp_q.push_back(pkt_t'{data: {err, 15'(mfc), 16'(csum)}, sop: 1'b0, eop: 1'b1});
        mfc++;
        if (err && merr < 255) merr++;
        pulse(size);
        for (int i = 0; i < m; i++) begin
            send_word(wbuf[i], gaps ? int'($urandom_range(0, 5)) : 0);
            if (i == ovr_at) begin
                pulse(int'($urandom_range(1, 9)));
                if (merr < 255) merr++;
                check("overrun_err_cnt", 64'(o_err_cnt), 64'(merr));
            end
        end
        wait_idle();
        check("frame_cnt", 64'(o_frame_cnt), 64'(16'(mfc)));
        check("err_cnt", 64'(o_err_cnt), 64'(merr));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst     = 1'b1;
        fr      = 1'b1;
        fsize   = 16'd7;
        in_data = 32'd0;
        in_vld  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        // Frame-ready held high across reset release must not start a frame
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_pkt_vld", 64'(o_pkt_vld), 64'(0));
        check("rst_frame_cnt", 64'(o_frame_cnt), 64'(0));
        check("rst_err_cnt", 64'(o_err_cnt), 64'(0));
        @(posedge clk);
        #1;
        fr = 1'b0;
        @(posedge clk);
        #1;

        // Directed 4-word frame, host always ready
        rdy_mode = 1;
        wbuf[0] = 32'h00010002;
        wbuf[1] = 32'h00030004;
        wbuf[2] = 32'h00050006;
        wbuf[3] = 32'h00070008;
        run_frame(4, 4, 1'b0, -1);

        // Empty frame: source must never see ready
        inrdy_seen = 0;
        run_frame(0, 0, 1'b0, -1);
        check("empty_no_in_rdy", 64'(inrdy_seen), 64'(0));

        // Host ready toggling every cycle
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        run_frame(3, 3, 1'b0, -1);

        // Source stalls after 2 of 5 words
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
        run_frame(5, 2, 1'b0, -1);

        // Second frame-ready edge while in DATA
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        run_frame(4, 4, 1'b0, 0);
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        run_frame(2, 2, 1'b0, -1);

        // Randomised frames, random host ready, occasional stalls
        rdy_mode = 0;
        for (int f = 0; f < 40; f++) begin
            int sz;
            int m;
            sz = int'($urandom_range(0, 12));
            m  = sz;
            if (sz > 0 && $urandom_range(0, 4) == 0) m = int'($urandom_range(0, sz - 1));
            for (int i = 0; i < sz; i++) wbuf[i] = $urandom;
            run_frame(sz, m, 1'b1, -1);
        end

        // Reset asserted mid-DATA abandons the packet
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
        exp_q.push_back(pkt_t'{data: {16'hA55A, 16'd6}, sop: 1'b1, eop: 1'b0});
        exp_q.push_back(pkt_t'{data: wbuf[0], sop: 1'b0, eop: 1'b0});
        exp_q.push_back(pkt_t'{data: wbuf[1], sop: 1'b0, eop: 1'b0});
        pulse(6);
        send_word(wbuf[0], 0);
        send_word(wbuf[1], 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_pkt_vld", 64'(o_pkt_vld), 64'(0));
        check("midrst_frame_cnt", 64'(o_frame_cnt), 64'(0));
        check("midrst_err_cnt", 64'(o_err_cnt), 64'(0));
        check("midrst_words_seen", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        mfc  = 0;
        merr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        run_frame(3, 3, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
